// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store sequencer driving the synchronous data memory.
// Define DMEM_LSU_SPLIT_EN to run misaligned half/word accesses bytewise.
module dmem_lsu #(
  parameter int          READ_LAT   = 1,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, SPLIT, RESP} state_t;

  localparam logic [1:0] LAT = 2'(READ_LAT);

  state_t      state, state_n;
  logic        we_q, we_n;
  logic [1:0]  cnt_q, cnt_n;
  logic [31:0] mem_addr_n, mem_datain_n, rsp_rdata_n;
  logic [2:0]  mem_memop_n;
  logic        mem_we_n, rsp_valid_n, rsp_err_n;
  logic [1:0]  nm1;
  logic        bad_op, over, misal;
`ifdef DMEM_LSU_SPLIT_EN
  logic [1:0]  k_q, k_n, nm1_q;
  logic [2:0]  op_q, op_n;
  logic [31:0] base_q, base_n, wdata_q, wdata_n, asm_q, asm_n;

  assign nm1_q = {op_q[1], op_q[1] | op_q[0]};
`endif

  assign req_ready = (state == IDLE) && !rst;

  always_comb begin
    state_n      = state;
    we_n         = we_q;
    cnt_n        = cnt_q;
    mem_addr_n   = mem_addr;
    mem_datain_n = mem_datain;
    mem_memop_n  = mem_memop;
    mem_we_n     = 1'b0;
    rsp_valid_n  = 1'b0;
    rsp_err_n    = 1'b0;
    rsp_rdata_n  = 32'h0;
`ifdef DMEM_LSU_SPLIT_EN
    k_n          = k_q;
    op_n         = op_q;
    base_n       = base_q;
    wdata_n      = wdata_q;
    asm_n        = asm_q;
`endif
    // size minus one: 0, 1 or 3 bytes beyond the base address
    nm1    = {req_memop[1], req_memop[1] | req_memop[0]};
    bad_op = (req_memop[1:0] == 2'b11) ||
             (req_memop[2] && (req_we || req_memop[1]));
    over   = ({1'b0, req_addr} + {31'h0, nm1}) > {1'b0, ADDR_LIMIT};
    misal  = (req_addr[1:0] & nm1) != 2'b00;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_n  = req_we;
          cnt_n = 2'd0;
          if (bad_op || over) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end
`ifdef DMEM_LSU_SPLIT_EN
          else if (misal) begin
            state_n      = SPLIT;
            k_n          = 2'd0;
            op_n         = req_memop;
            base_n       = req_addr;
            wdata_n      = req_wdata;
            asm_n        = 32'h0;
            mem_addr_n   = req_addr;
            mem_memop_n  = req_we ? 3'b000 : 3'b100;
            mem_datain_n = {24'h0, req_wdata[7:0]};
            mem_we_n     = req_we;
          end
`else
          else if (misal) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end
`endif
          else begin
            state_n      = ACCESS;
            mem_addr_n   = req_addr;
            mem_memop_n  = req_memop;
            mem_datain_n = req_wdata;
            mem_we_n     = req_we;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n   = 2'd1;
        end
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = mem_dataout;
        end else begin
          cnt_n = cnt_q + 2'd1;
        end
      end
`ifdef DMEM_LSU_SPLIT_EN
      SPLIT: begin
        if (we_q) begin
          if (k_q == nm1_q) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
          end else begin
            k_n          = k_q + 2'd1;
            mem_addr_n   = base_q + {30'h0, k_n};
            mem_datain_n = {24'h0, wdata_q[{k_n, 3'b000} +: 8]};
            mem_we_n     = 1'b1;
          end
        end else if (cnt_q != LAT) begin
          cnt_n = cnt_q + 2'd1;
        end else begin
          asm_n[{k_q, 3'b000} +: 8] = mem_dataout[7:0];
          if (k_q == nm1_q) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            if (nm1_q == 2'd1)
              rsp_rdata_n = op_q[2] ? {16'h0, asm_n[15:0]}
                                    : {{16{asm_n[15]}}, asm_n[15:0]};
            else
              rsp_rdata_n = asm_n;
          end else begin
            k_n        = k_q + 2'd1;
            cnt_n      = 2'd0;
            mem_addr_n = base_q + {30'h0, k_n};
          end
        end
      end
`endif
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      cnt_q      <= 2'd0;
      mem_addr   <= 32'h0;
      mem_datain <= 32'h0;
      mem_memop  <= 3'b010;
      mem_we     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'h0;
`ifdef DMEM_LSU_SPLIT_EN
      k_q        <= 2'd0;
      op_q       <= 3'b010;
      base_q     <= 32'h0;
      wdata_q    <= 32'h0;
      asm_q      <= 32'h0;
`endif
    end else begin
      state      <= state_n;
      we_q       <= we_n;
      cnt_q      <= cnt_n;
      mem_addr   <= mem_addr_n;
      mem_datain <= mem_datain_n;
      mem_memop  <= mem_memop_n;
      mem_we     <= mem_we_n;
      rsp_valid  <= rsp_valid_n;
      rsp_err    <= rsp_err_n;
      rsp_rdata  <= rsp_rdata_n;
`ifdef DMEM_LSU_SPLIT_EN
      k_q        <= k_n;
      op_q       <= op_n;
      base_q     <= base_n;
      wdata_q    <= wdata_n;
      asm_q      <= asm_n;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench, READ_LAT=1 (u1) and READ_LAT=2 (u2) on one RAM.
// Misaligned expectations follow DMEM_LSU_SPLIT_EN.
module tb_dmem_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rv, sel, req_we;
  logic [2:0]  req_memop;
  logic [31:0] req_addr, req_wdata;

  logic        rdy1, rv1, err1, we1;
  logic [31:0] rd1, ma1, md1, do1;
  logic [2:0]  mo1;
  logic        rdy2, rv2, err2, we2;
  logic [31:0] rd2, ma2, md2, do2, p2;
  logic [2:0]  mo2;
  logic        we2_seen = 1'b0;

  logic [7:0]  ram [0:65535];

  int total = 0;
  int bad = 0;

  dmem_lsu #(.READ_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv && !sel), .req_ready(rdy1),
    .req_we(req_we), .req_memop(req_memop), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
    .rsp_err(err1), .mem_addr(ma1), .mem_datain(md1),
    .mem_memop(mo1), .mem_we(we1), .mem_dataout(do1)
  );

  dmem_lsu #(.READ_LAT(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(rv && sel), .req_ready(rdy2),
    .req_we(req_we), .req_memop(req_memop), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_rdata(rd2),
    .rsp_err(err2), .mem_addr(ma2), .mem_datain(md2),
    .mem_memop(mo2), .mem_we(we2), .mem_dataout(do2)
  );

  function automatic logic [31:0] rd(input logic [31:0] a,
                                     input logic [2:0] op);
    logic [15:0] i;
    logic [31:0] w;
    i = a[15:0];
    w = {ram[16'(i + 16'd3)], ram[16'(i + 16'd2)],
         ram[16'(i + 16'd1)], ram[i]};
    case (op[1:0])
      2'b00:   rd = op[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2'b01:   rd = op[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: rd = w;
    endcase
  endfunction

  // reference memory: read-before-write, u2 only ever reads
  always @(posedge clk) begin
    do1 <= rd(ma1, mo1);
    p2  <= rd(ma2, mo2);
    do2 <= p2;
    if (we2) we2_seen <= 1'b1;
    if (we1) begin
      ram[ma1[15:0]] <= md1[7:0];
      if (mo1[1:0] != 2'b00)
        ram[16'(ma1[15:0] + 16'd1)] <= md1[15:8];
      if (mo1[1:0] == 2'b10) begin
        ram[16'(ma1[15:0] + 16'd2)] <= md1[23:16];
        ram[16'(ma1[15:0] + 16'd3)] <= md1[31:24];
      end
    end
  end

  logic        o_rdy, o_rv, o_err, o_we;
  logic [31:0] o_rd, o_ma, o_md;
  assign o_rdy = sel ? rdy2 : rdy1;
  assign o_rv  = sel ? rv2  : rv1;
  assign o_err = sel ? err2 : err1;
  assign o_we  = sel ? we2  : we1;
  assign o_rd  = sel ? rd2  : rd1;
  assign o_ma  = sel ? ma2  : ma1;
  assign o_md  = sel ? md2  : md1;

  int          lat, wes;
  logic [31:0] got_rd;
  logic        got_err, moved;
  logic [31:0] wa [8];
  logic [7:0]  wb [8];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one request, then follow it to its response
  task automatic run(input logic w, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] d);
    bit done;
    chk("ready", {31'h0, o_rdy}, 32'h1);
    req_we = w; req_memop = op; req_addr = a; req_wdata = d; rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0;
    lat = 0; wes = 0; moved = 1'b0; done = 1'b0;
    got_rd = 32'h0; got_err = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (o_we && wes < 8) begin
        wa[wes] = o_ma; wb[wes] = o_md[7:0]; wes++;
      end
      if (o_rv) begin
        done = 1'b1; lat = c; got_rd = o_rd; got_err = o_err;
      end else begin
        if (o_ma != a) moved = 1'b1;
        @(posedge clk); #1;
      end
    end
    if (done) begin
      @(posedge clk); #1;
      chk("rsp_pulse", {31'h0, o_rv}, 32'h0);
    end
  endtask

  task automatic rsp(input string tag, input int l, input logic [31:0] r,
                     input logic e, input int nw);
    chk({tag, "_lat"}, 32'(lat), 32'(l));
    chk({tag, "_rdata"}, got_rd, r);
    chk({tag, "_err"}, {31'h0, got_err}, {31'h0, e});
    chk({tag, "_wes"}, 32'(wes), 32'(nw));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rv = 1'b0; sel = 1'b0; req_we = 1'b0;
    req_memop = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, rdy1}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rv1}, 32'h0);
    chk("rst_rsp_rdata", rd1, 32'h0);
    chk("rst_rsp_err", {31'h0, err1}, 32'h0);
    chk("rst_mem_addr", ma1, 32'h0);
    chk("rst_mem_datain", md1, 32'h0);
    chk("rst_mem_memop", {29'h0, mo1}, 32'h2);
    chk("rst_mem_we", {31'h0, we1}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'h0, rdy1}, 32'h1);
    @(posedge clk); #1;

    run(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    rsp("sw10", 2, 32'h0, 1'b0, 1);
    chk("sw10_addr", wa[0], 32'h10);
    run(1'b0, 3'b010, 32'h10, 32'h0);
    rsp("lw10", 3, 32'hDEAD_BEEF, 1'b0, 0);

    run(1'b1, 3'b010, 32'h10, 32'h80FF_0000);
    rsp("sw10b", 2, 32'h0, 1'b0, 1);
    run(1'b0, 3'b000, 32'h13, 32'h0);
    rsp("lb13", 3, 32'hFFFF_FF80, 1'b0, 0);
    run(1'b0, 3'b100, 32'h13, 32'h0);
    rsp("lbu13", 3, 32'h0000_0080, 1'b0, 0);
    run(1'b0, 3'b001, 32'h12, 32'h0);
    rsp("lh12", 3, 32'hFFFF_80FF, 1'b0, 0);

    run(1'b0, 3'b010, 32'h0001_0000, 32'h0);
    rsp("lw_range", 1, 32'h0, 1'b1, 0);
    run(1'b0, 3'b011, 32'h0, 32'h0);
    rsp("op011", 1, 32'h0, 1'b1, 0);
    run(1'b1, 3'b100, 32'h0, 32'hFF);
    rsp("sbu_illegal", 1, 32'h0, 1'b1, 0);
    run(1'b0, 3'b010, 32'hFFFD, 32'h0);
    rsp("lw_fffd", 1, 32'h0, 1'b1, 0);
    run(1'b1, 3'b010, 32'hFFFC, 32'h5A5A_1234);
    rsp("sw_fffc", 2, 32'h0, 1'b0, 1);
    run(1'b0, 3'b010, 32'hFFFC, 32'h0);
    rsp("lw_fffc", 3, 32'h5A5A_1234, 1'b0, 0);

`ifdef DMEM_LSU_SPLIT_EN
    run(1'b1, 3'b010, 32'h21, 32'h1122_3344);
    rsp("sp_sw", 5, 32'h0, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("sp_sw_addr", wa[i], 32'h21 + 32'(i));
    end
    chk("sp_sw_b0", {24'h0, wb[0]}, 32'h44);
    chk("sp_sw_b1", {24'h0, wb[1]}, 32'h33);
    chk("sp_sw_b2", {24'h0, wb[2]}, 32'h22);
    chk("sp_sw_b3", {24'h0, wb[3]}, 32'h11);
    run(1'b0, 3'b010, 32'h21, 32'h0);
    rsp("sp_lw", 9, 32'h1122_3344, 1'b0, 0);
    run(1'b0, 3'b001, 32'h23, 32'h0);
    rsp("sp_lh", 5, 32'h0000_1122, 1'b0, 0);

    run(1'b1, 3'b010, 32'h20, 32'h0);
    run(1'b1, 3'b010, 32'h24, 32'h0);
    req_we = 1'b1; req_memop = 3'b010;
    req_addr = 32'h21; req_wdata = 32'hAABB_CCDD; rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0;
    chk("ab_we0", {31'h0, we1}, 32'h1);
    chk("ab_addr0", ma1, 32'h21);
    @(posedge clk); #1;
    chk("ab_we1", {31'h0, we1}, 32'h1);
    chk("ab_addr1", ma1, 32'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ab_we_off", {31'h0, we1}, 32'h0);
    chk("ab_no_rsp", {31'h0, rv1}, 32'h0);
    @(posedge clk); #1;
    chk("ab_we_off2", {31'h0, we1}, 32'h0);
    chk("ab_no_rsp2", {31'h0, rv1}, 32'h0);
    chk("ab_rdy_rst", {31'h0, rdy1}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ab_rdy", {31'h0, rdy1}, 32'h1);
    @(posedge clk); #1;
    run(1'b0, 3'b010, 32'h20, 32'h0);
    rsp("ab_lw20", 3, 32'h00CC_DD00, 1'b0, 0);
    run(1'b0, 3'b010, 32'h24, 32'h0);
    rsp("ab_lw24", 3, 32'h0, 1'b0, 0);
`else
    run(1'b1, 3'b010, 32'h21, 32'h1122_3344);
    rsp("mis_sw", 1, 32'h0, 1'b1, 0);
    run(1'b0, 3'b010, 32'h21, 32'h0);
    rsp("mis_lw", 1, 32'h0, 1'b1, 0);
    run(1'b0, 3'b001, 32'h23, 32'h0);
    rsp("mis_lh", 1, 32'h0, 1'b1, 0);
`endif

    sel = 1'b1;
    #1;
    run(1'b0, 3'b101, 32'h12, 32'h0);
    rsp("lat2_lhu", 4, 32'h0000_80FF, 1'b0, 0);
    chk("lat2_addr_stable", {31'h0, moved}, 32'h0);
    chk("lat2_no_we", {31'h0, we2_seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
